// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold control
// and a saturating count of the load-use bubbles it inserts.
module id_ex_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic            id_regwrite,
  input  logic            id_memwrite,
  input  logic            id_memread,
  input  logic            id_alusrc,
  input  logic [2:0]      id_aluop,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [2:0]      id_funct3,
  input  logic            flush_i,
  input  logic            hold_i,
  output logic            ex_valid,
  output logic            ex_regwrite,
  output logic            ex_memwrite,
  output logic            ex_memread,
  output logic            ex_alusrc,
  output logic [2:0]      ex_aluop,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_funct3,
  output logic            stall_o,
  output logic [CNTW-1:0] stall_cnt
);

  typedef struct packed {
    logic            valid;
    logic            regwrite;
    logic            memwrite;
    logic            memread;
    logic            alusrc;
    logic [2:0]      aluop;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
  } slot_t;

  slot_t           ex_d, ex_q;
  slot_t           id_slot;
  logic [CNTW-1:0] stall_cnt_d, stall_cnt_q;
  logic            load_use;

  // Gather the decode slot; an empty slot must not carry live control bits.
  always_comb begin
    id_slot          = '0;
    id_slot.valid    = id_valid;
    id_slot.pc       = id_pc;
    id_slot.rs1_data = id_rs1_data;
    id_slot.rs2_data = id_rs2_data;
    id_slot.imm      = id_imm;
    id_slot.rs1      = id_rs1;
    id_slot.rs2      = id_rs2;
    id_slot.rd       = id_rd;
    id_slot.funct3   = id_funct3;
    if (id_valid) begin
      id_slot.regwrite = id_regwrite;
      id_slot.memwrite = id_memwrite;
      id_slot.memread  = id_memread;
      id_slot.alusrc   = id_alusrc;
      id_slot.aluop    = id_aluop;
    end
  end

  // Load in EX whose destination (not x0) is a source of the decode slot.
  always_comb begin
    load_use = ex_q.valid & ex_q.memread & (ex_q.rd != 5'd0) & id_valid &
               ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));
  end

  assign stall_o = (load_use | hold_i) & ~flush_i;

  // Next-state selection: flush > hold > load-use bubble > normal load.
  always_comb begin
    ex_d        = ex_q;
    stall_cnt_d = stall_cnt_q;
    if (flush_i) begin
      ex_d = '0;
    end else if (hold_i) begin
      ex_d = ex_q;
    end else if (load_use) begin
      ex_d = '0;
      if (stall_cnt_q != {CNTW{1'b1}}) begin
        stall_cnt_d = stall_cnt_q + CNTW'(1);
      end
    end else begin
      ex_d = id_slot;
    end
  end

  // State registers; reset wins over every other control.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_regwrite = ex_q.regwrite;
  assign ex_memwrite = ex_q.memwrite;
  assign ex_memread  = ex_q.memread;
  assign ex_alusrc   = ex_q.alusrc;
  assign ex_aluop    = ex_q.aluop;
  assign ex_pc       = ex_q.pc;
  assign ex_rs1_data = ex_q.rs1_data;
  assign ex_rs2_data = ex_q.rs2_data;
  assign ex_imm      = ex_q.imm;
  assign ex_rs1      = ex_q.rs1;
  assign ex_rs2      = ex_q.rs2;
  assign ex_rd       = ex_q.rd;
  assign ex_funct3   = ex_q.funct3;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus a randomized
// run, all compared against a rule-level model of the EX slot.
module tb_id_ex_stage;
  localparam int XLEN = 32;
  localparam int CNTW = 2;
  localparam int CMAX = 3;

  typedef struct packed {
    logic            valid;
    logic            regwrite;
    logic            memwrite;
    logic            memread;
    logic            alusrc;
    logic [2:0]      aluop;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
  } slot_t;

  logic clk = 1'b0;
  logic rst, flush, hold;
  slot_t id;
  slot_t ex_obs;

  logic            ex_valid, ex_regwrite, ex_memwrite, ex_memread, ex_alusrc;
  logic [2:0]      ex_aluop, ex_funct3;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd;
  logic            stall_o;
  logic [CNTW-1:0] stall_cnt;

  int checks = 0;
  int passed = 0;

  // Model state: what EX should hold, and the bubble count.
  slot_t m_ex;
  int    m_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id.valid), .id_regwrite(id.regwrite), .id_memwrite(id.memwrite),
    .id_memread(id.memread), .id_alusrc(id.alusrc), .id_aluop(id.aluop),
    .id_pc(id.pc), .id_rs1_data(id.rs1_data), .id_rs2_data(id.rs2_data),
    .id_imm(id.imm), .id_rs1(id.rs1), .id_rs2(id.rs2), .id_rd(id.rd),
    .id_funct3(id.funct3), .flush_i(flush), .hold_i(hold),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memwrite(ex_memwrite),
    .ex_memread(ex_memread), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_funct3(ex_funct3), .stall_o(stall_o), .stall_cnt(stall_cnt)
  );

  assign ex_obs = {ex_valid, ex_regwrite, ex_memwrite, ex_memread, ex_alusrc, ex_aluop,
                   ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3};

  function automatic slot_t rand_slot();
    slot_t s;
    s.valid    = ($urandom_range(0, 9) != 0);
    s.regwrite = 1'($urandom);
    s.memwrite = 1'($urandom);
    s.memread  = 1'($urandom);
    s.alusrc   = 1'($urandom);
    s.aluop    = 3'($urandom_range(0, 6));
    s.pc       = $urandom;
    s.rs1_data = $urandom;
    s.rs2_data = $urandom;
    s.imm      = $urandom;
    s.rs1      = 5'($urandom_range(0, 7));
    s.rs2      = 5'($urandom_range(0, 7));
    s.rd       = 5'($urandom_range(0, 7));
    s.funct3   = 3'($urandom);
    return s;
  endfunction

  // A hazard exists when a real load in EX writes a nonzero register read by ID.
  function automatic logic m_hazard();
    return m_ex.valid && m_ex.memread && m_ex.rd != 0 && id.valid &&
           (m_ex.rd == id.rs1 || m_ex.rd == id.rs2);
  endfunction

  function automatic logic m_stall();
    return (m_hazard() || hold) && !flush;
  endfunction

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    slot_t nxt;
    int    ncnt;
    nxt  = m_ex;
    ncnt = m_cnt;
    if (rst) begin
      nxt  = '0;
      ncnt = 0;
    end else if (flush) begin
      nxt = '0;
    end else if (hold) begin
      nxt = m_ex;
    end else if (m_hazard()) begin
      nxt  = '0;
      ncnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
    end else begin
      nxt = id;
      if (!id.valid) begin
        nxt.regwrite = 1'b0;
        nxt.memwrite = 1'b0;
        nxt.memread  = 1'b0;
        nxt.alusrc   = 1'b0;
        nxt.aluop    = 3'b000;
      end
    end
    @(posedge clk);
    m_ex  = nxt;
    m_cnt = ncnt;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      rst = 1'b1; id = rand_slot(); flush = 1'($urandom); hold = 1'($urandom);
      tick();
      checks++;
      if (ex_obs !== '0) $display("FAIL reset_ex: got %h required 0", ex_obs);
      else passed++;
      checks++;
      if (stall_cnt !== '0) $display("FAIL reset_cnt: got %0d required 0", stall_cnt);
      else passed++;
    end
    rst = 1'b0; flush = 1'b0; hold = 1'b0;
    #1;
    checks++;
    if (stall_o !== 1'b0) $display("FAIL reset_stall: got %b required 0", stall_o);
    else passed++;
  endtask

  task automatic test_normal();
    id = '0; id.valid = 1'b1; id.aluop = 3'b001; id.rd = 5'd5; id.rs1_data = 32'h10;
    #1;
    checks++;
    if (stall_o !== 1'b0) $display("FAIL normal_stall: got %b required 0", stall_o);
    else passed++;
    tick();
    checks++;
    if ({ex_valid, ex_aluop, ex_rd, ex_rs1_data} !== {1'b1, 3'b001, 5'd5, 32'h10})
      $display("FAIL normal_fields: got v=%b op=%0d rd=%0d d=%h required v=1 op=1 rd=5 d=10",
               ex_valid, ex_aluop, ex_rd, ex_rs1_data);
    else passed++;
    // Empty decode slot: data flows, controls are forced off.
    id = rand_slot(); id.valid = 1'b0; id.regwrite = 1'b1; id.memread = 1'b1; id.aluop = 3'd5;
    tick();
    checks++;
    if (ex_obs !== m_ex) $display("FAIL normal_invalid: got %h required %h", ex_obs, m_ex);
    else passed++;
  endtask

  task automatic test_load_use();
    int c0;
    c0 = m_cnt;
    id = rand_slot(); id.valid = 1'b1; id.memread = 1'b1; id.rd = 5'd3;
    tick();
    id = rand_slot(); id.valid = 1'b1; id.memread = 1'b0; id.rs1 = 5'd4; id.rs2 = 5'd3;
    id.rd = 5'd6;
    #1;
    checks++;
    if (stall_o !== 1'b1) $display("FAIL lu_stall: got %b required 1", stall_o);
    else passed++;
    tick();
    checks++;
    if (ex_valid !== 1'b0 || int'(stall_cnt) != c0 + 1)
      $display("FAIL lu_bubble: got v=%b cnt=%0d required v=0 cnt=%0d", ex_valid, stall_cnt,
               c0 + 1);
    else passed++;
    checks++;
    if (stall_o !== 1'b0) $display("FAIL lu_release: got %b required 0", stall_o);
    else passed++;
    tick();
    checks++;
    if (ex_obs !== m_ex || ex_rd !== 5'd6)
      $display("FAIL lu_enter: got %h required %h", ex_obs, m_ex);
    else passed++;
  endtask

  task automatic test_x0();
    int c0;
    id = rand_slot(); id.valid = 1'b1; id.memread = 1'b1; id.rd = 5'd0;
    tick();
    c0 = m_cnt;
    id = rand_slot(); id.valid = 1'b1; id.rs1 = 5'd0; id.rs2 = 5'd0;
    #1;
    checks++;
    if (stall_o !== 1'b0) $display("FAIL x0_stall: got %b required 0", stall_o);
    else passed++;
    tick();
    checks++;
    if (ex_valid !== 1'b1 || int'(stall_cnt) != c0 || ex_obs !== m_ex)
      $display("FAIL x0_load: got v=%b cnt=%0d required v=1 cnt=%0d", ex_valid, stall_cnt, c0);
    else passed++;
  endtask

  task automatic test_flush_hazard();
    int c0;
    id = rand_slot(); id.valid = 1'b1; id.memread = 1'b1; id.rd = 5'd3;
    tick();
    c0 = m_cnt;
    id = rand_slot(); id.valid = 1'b1; id.rs1 = 5'd3; flush = 1'b1;
    #1;
    checks++;
    if (stall_o !== 1'b0) $display("FAIL flush_stall: got %b required 0", stall_o);
    else passed++;
    tick();
    flush = 1'b0;
    checks++;
    if (ex_obs !== '0 || int'(stall_cnt) != c0)
      $display("FAIL flush_bubble: got %h cnt=%0d required 0 cnt=%0d", ex_obs, stall_cnt, c0);
    else passed++;
  endtask

  task automatic test_hold();
    slot_t held;
    id = rand_slot(); id.valid = 1'b1; id.memread = 1'b0;
    tick();
    held = m_ex;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id = rand_slot();
      #1;
      checks++;
      if (stall_o !== 1'b1) $display("FAIL hold_stall: got %b required 1", stall_o);
      else passed++;
      tick();
      checks++;
      if (ex_obs !== held) $display("FAIL hold_keep: got %h required %h", ex_obs, held);
      else passed++;
    end
    hold = 1'b0;
    id = rand_slot(); id.valid = 1'b1;
    tick();
    checks++;
    if (ex_obs !== id) $display("FAIL hold_release: got %h required %h", ex_obs, id);
    else passed++;
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      id = rand_slot(); id.valid = 1'b1; id.memread = 1'b1; id.rd = 5'd3;
      tick();
      id = rand_slot(); id.valid = 1'b1; id.memread = 1'b0; id.rs1 = 5'd3;
      tick();
      checks++;
      if (int'(stall_cnt) != ((i + 1 < CMAX) ? i + 1 : CMAX))
        $display("FAIL sat_cnt: got %0d required %0d", stall_cnt,
                 (i + 1 < CMAX) ? i + 1 : CMAX);
      else passed++;
    end
    rst = 1'b1; hold = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; hold = 1'b0; flush = 1'b0;
    checks++;
    if (ex_obs !== '0 || stall_cnt !== '0)
      $display("FAIL sat_reset: got %h cnt=%0d required 0 cnt=0", ex_obs, stall_cnt);
    else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 9) == 0);
      hold  = ($urandom_range(0, 6) == 0);
      id    = rand_slot();
      #1;
      checks++;
      if (stall_o !== m_stall())
        $display("FAIL rand_stall[%0d]: got %b required %b", i, stall_o, m_stall());
      else passed++;
      tick();
      checks++;
      if (ex_obs !== m_ex || int'(stall_cnt) != m_cnt)
        $display("FAIL rand_state[%0d]: got %h cnt=%0d required %h cnt=%0d", i, ex_obs,
                 stall_cnt, m_ex, m_cnt);
      else passed++;
    end
    rst = 1'b0; flush = 1'b0; hold = 1'b0;
  endtask

  initial begin
    m_ex = '0; m_cnt = 0;
    rst = 1'b1; flush = 1'b0; hold = 1'b0; id = '0;
    test_reset();
    test_normal();
    test_load_use();
    test_x0();
    test_flush_hazard();
    test_hold();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter CNTW, default 16, stall-counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports id_valid  input  1  decode slot holds a real instruction.
REQ-006 SHALL have ports id_regwrite, id_memwrite, id_memread, id_alusrc  input  1 each  decoded control bits.
REQ-007 SHALL have port id_aluop  input  3  decoded ALU op (000 ADD … 110 SR).
REQ-008 SHALL have ports id_pc, id_rs1_data, id_rs2_data, id_imm  input  XLEN each  operands.
REQ-009 SHALL have ports id_rs1, id_rs2, id_rd  input  5 each  register indices.
REQ-010 SHALL have port id_funct3  input  3  passed through for branch/load width.
REQ-011 SHALL have ports flush_i  input  1  kill the instruction entering EX; hold_i  input  1  freeze EX (downstream stall).
REQ-012 SHALL have ex_* outputs mirroring every id_* input above (same widths), registered, plus ex_valid  output  1.
REQ-013 SHALL have port stall_o  output  1  hold PC and IF/ID this cycle (combinational).
REQ-014 SHALL have port stall_cnt  output  CNTW  saturating count of load-use bubbles inserted.

Function
REQ-015 SHALL evaluate load_use = ex_valid & ex_memread & (ex_rd != 0) & id_valid & (ex_rd == id_rs1 | ex_rd == id_rs2).
REQ-016 SHALL drive stall_o = (load_use & ~flush_i) | (hold_i & ~flush_i).
REQ-017 SHALL apply per-edge priority: rst > flush_i > hold_i > load_use > normal load.
REQ-018 On flush_i SHALL load a bubble: ex_valid=0, ex_regwrite=ex_memwrite=ex_memread=ex_alusrc=0, ex_aluop=000; data/index fields don't-care but SHALL be zeroed.
REQ-019 On hold_i (no flush) SHALL keep every ex_* register unchanged, including ex_valid.
REQ-020 On load_use (no flush, no hold) SHALL load a bubble as REQ-018 and increment stall_cnt.
REQ-021 Otherwise SHALL load all id_* fields into ex_*; ex_valid=id_valid; if id_valid=0 control bits SHALL be forced 0.
REQ-022 Latency SHALL be exactly one cycle from id_* to ex_* on a normal load.
REQ-023 Load-use SHALL cost exactly one bubble: after the bubble ex_memread=0, so load_use deasserts and the held instruction enters EX next edge.
REQ-024 stall_cnt SHALL saturate at 2^CNTW-1 and never wrap.
REQ-025 Matching on x0 (ex_rd=0) SHALL never stall.
REQ-026 flush_i concurrent with load_use SHALL produce bubble, stall_o=0, no stall_cnt increment.
REQ-027 ex_* outputs SHALL be driven only from registers; no combinational path id_* -> ex_*.

Reset
REQ-028 On rst SHALL set ex_valid=0, every ex_* field=0, stall_cnt=0, regardless of flush_i/hold_i.
REQ-029 rst asserted mid-stall SHALL clear state; first post-reset cycle SHALL show stall_o=0 unless hold_i=1.

Verification
REQ-030 Normal: id_valid=1, id_aluop=001, id_rd=5, id_rs1_data=0x10 -> next edge ex_valid=1, ex_aluop=001, ex_rd=5, ex_rs1_data=0x10, stall_o=0.
REQ-031 Load-use: EX holds lw rd=3 (ex_memread=1); ID has rs2=3 -> stall_o=1, next edge ex_valid=0, stall_cnt=1; following edge ID instruction in EX, stall_o=0.
REQ-032 x0 load: EX lw rd=0, ID rs1=0 -> stall_o=0, normal load, stall_cnt unchanged.
REQ-033 Flush+hazard: load_use condition and flush_i=1 same cycle -> stall_o=0, ex_valid=0, stall_cnt unchanged.
REQ-034 Hold: hold_i=1 for 3 cycles with changing id_* -> ex_* constant, stall_o=1; on release the current id_* loads.
REQ-035 Saturation/reset: CNTW=2, force 5 load-use bubbles -> stall_cnt=3; assert rst -> all ex_*=0, stall_cnt=0.
